// File: rtl/bcd_display_scheduler.sv
// ============================================================================
// Module   : bcd_display_scheduler
// Brief    : Three requesters share one shift-and-add-3 binary-to-BCD engine;
//            results drive three two-digit seven-segment readouts (HEX0..HEX5).
//            Optional macro BLANK_LEADING_ZERO_EN blanks a zero tens digit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_scheduler (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [6:0] val0,
    input  logic [6:0] val1,
    input  logic [6:0] val2,
    output logic [2:0] ack,
    output logic       busy,
    output logic [2:0] over,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3,
    output logic [7:0] HEX4,
    output logic [7:0] HEX5
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_shift = 2'd1;
    localparam logic [1:0] c_store = 2'd2;

    localparam logic [2:0] c_last_shift = 3'd6;
    localparam logic [7:0] c_blank      = 8'hFF;
    localparam logic [7:0] c_dash       = 8'hBF;

    logic [1:0]  r_state;
    logic [1:0]  r_ptr;
    logic [1:0]  r_grant;
    logic [6:0]  r_bin;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic [2:0]  r_ack;
    logic [2:0]  r_over;
    logic [7:0]  r_hex [0:5];

    logic [1:0]  w_p1;
    logic [1:0]  w_p2;
    logic [1:0]  w_grant;
    logic [6:0]  w_val;
    logic [11:0] w_adj;
    logic        w_over_new;
    logic [7:0]  w_tens_seg;
    logic [7:0]  w_ones_seg;

    function automatic logic [3:0] f_add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    function automatic logic [7:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Round-robin: search ptr, ptr+1, ptr+2 (mod 3) for the first active request.
    always_comb begin
        w_p1 = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
        w_p2 = (r_ptr == 2'd0) ? 2'd2 : r_ptr - 2'd1;
        if (req[r_ptr])
            w_grant = r_ptr;
        else if (req[w_p1])
            w_grant = w_p1;
        else
            w_grant = w_p2;
    end

    always_comb begin
        case (w_grant)
            2'd0:    w_val = val0;
            2'd1:    w_val = val1;
            default: w_val = val2;
        endcase
    end

    assign w_adj      = {f_add3(r_bcd[11:8]), f_add3(r_bcd[7:4]), f_add3(r_bcd[3:0])};
    assign w_over_new = (r_bcd[11:8] != 4'd0) || (r_bcd[7:4] > 4'd9);

    always_comb begin
        w_ones_seg = w_over_new ? c_dash : f_seg(r_bcd[3:0]);
        w_tens_seg = w_over_new ? c_dash : f_seg(r_bcd[7:4]);
`ifdef BLANK_LEADING_ZERO_EN
        if (!w_over_new && r_bcd[7:4] == 4'd0)
            w_tens_seg = c_blank;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_idle;
            r_ptr   <= 2'd0;
            r_grant <= 2'd0;
            r_bin   <= 7'd0;
            r_bcd   <= 12'd0;
            r_cnt   <= 3'd0;
            r_ack   <= 3'd0;
            r_over  <= 3'd0;
            for (int i = 0; i < 6; i++)
                r_hex[i] <= c_blank;
        end else begin
            r_ack <= 3'd0;
            case (r_state)
                c_idle: begin
                    if (|req) begin
                        r_grant <= w_grant;
                        r_bin   <= w_val;
                        r_bcd   <= 12'd0;
                        r_cnt   <= 3'd0;
                        r_state <= c_shift;
                    end
                end
                c_shift: begin
                    {r_bcd, r_bin} <= {w_adj[10:0], r_bin, 1'b0};
                    r_cnt          <= r_cnt + 3'd1;
                    if (r_cnt == c_last_shift)
                        r_state <= c_store;
                end
                c_store: begin
                    for (int i = 0; i < 3; i++) begin
                        if (r_grant == 2'(i)) begin
                            r_hex[2*i]   <= w_ones_seg;
                            r_hex[2*i+1] <= w_tens_seg;
                            r_over[i]    <= w_over_new;
                            r_ack[i]     <= 1'b1;
                        end
                    end
                    r_ptr   <= (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;
                    r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign ack  = r_ack;
    assign over = r_over;
    assign busy = (r_state != c_idle);
    assign HEX0 = r_hex[0];
    assign HEX1 = r_hex[1];
    assign HEX2 = r_hex[2];
    assign HEX3 = r_hex[3];
    assign HEX4 = r_hex[4];
    assign HEX5 = r_hex[5];

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_scheduler.sv
// ============================================================================
// Module   : tb_bcd_display_scheduler
// Brief    : Randomized self-checking bench for bcd_display_scheduler against a
//            decimal-arithmetic display model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_scheduler;

    logic       clock;
    logic       reset;
    logic [2:0] req;
    logic [6:0] val0, val1, val2;
    logic [2:0] ack;
    logic       busy;
    logic [2:0] over;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [7:0] hx [6];

    int total = 0;
    int bad   = 0;

    // Model: last displayed value per channel, or nothing since reset.
    int unsigned m_val   [3];
    bit          m_valid [3];

    bcd_display_scheduler dut (
        .clock(clock), .reset(reset), .req(req),
        .val0(val0), .val1(val1), .val2(val2),
        .ack(ack), .busy(busy), .over(over),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
        .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    assign hx[0] = HEX0;
    assign hx[1] = HEX1;
    assign hx[2] = HEX2;
    assign hx[3] = HEX3;
    assign hx[4] = HEX4;
    assign hx[5] = HEX5;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] digit_seg(int unsigned d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_hex(int idx);
        int ch = idx / 2;
        bit is_tens = (idx % 2) == 1;
        int unsigned d;
        if (!m_valid[ch]) return 8'hFF;
        if (m_val[ch] > 99) return 8'hBF;
        d = is_tens ? m_val[ch] / 10 : m_val[ch] % 10;
`ifdef BLANK_LEADING_ZERO_EN
        if (is_tens && d == 0) return 8'hFF;
`endif
        return digit_seg(d);
    endfunction

    function automatic logic [2:0] exp_over();
        logic [2:0] o;
        for (int c = 0; c < 3; c++) o[c] = m_valid[c] && (m_val[c] > 99);
        return o;
    endfunction

    task automatic set_val(int ch, logic [6:0] v);
        case (ch)
            0: val0 = v;
            1: val1 = v;
            default: val2 = v;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 3'b000;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin m_valid[c] = 0; m_val[c] = 0; end
    endtask

    // Raise req[ch] with value v and wait (bounded) for ack[ch]; drop req in the ack cycle.
    task automatic do_req(int ch, logic [6:0] v, output int lat, output bit ok);
        set_val(ch, v);
        req[ch] = 1'b1;
        lat = 0;
        ok  = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            lat++;
            if (ack[ch]) ok = 1;
        end
        req[ch] = 1'b0;
        if (ok) begin m_val[ch] = v; m_valid[ch] = 1; end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 3'b000; val0 = 7'd0; val1 = 7'd0; val2 = 7'd0;
        tick(); tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin m_valid[c] = 0; m_val[c] = 0; end
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 6; k++) begin
                total++;
                if (hx[k] !== 8'hFF) begin
                    bad++; $display("FAIL reset_hex%0d: actual=%h required=ff", k, hx[k]);
                end
            end
            total++;
            if ({ack, busy, over} !== 7'd0) begin
                bad++; $display("FAIL reset_ctl: ack/busy/over actual=%b/%b/%b required=0", ack, busy, over);
            end
            for (int n = 0; n < 5; n++) tick();
        end
    endtask

    task automatic test_basic();
        int lat; bit ok;
        logic [7:0] exp_o [2];
        logic [6:0] vals [2];
        vals[0] = 7'd22; vals[1] = 7'd25;
        exp_o[0] = 8'hA4; exp_o[1] = 8'h92;
        for (int t = 0; t < 2; t++) begin
            do_req(0, vals[t], lat, ok);
            total++;
            if (!ok || lat != 9) begin
                bad++; $display("FAIL basic_latency: actual=%0d ok=%0d required=9", lat, ok);
            end
            total++;
            if ({HEX1, HEX0} !== {8'hA4, exp_o[t]}) begin
                bad++; $display("FAIL basic_hex: actual=%h %h required=a4 %h", HEX1, HEX0, exp_o[t]);
            end
            total++;
            if ({HEX5, HEX4, HEX3, HEX2} !== 32'hFFFF_FFFF || busy !== 1'b0) begin
                bad++; $display("FAIL basic_other: actual=%h%h%h%h busy=%b required=ffffffff busy=0",
                                HEX5, HEX4, HEX3, HEX2, busy);
            end
            tick();
            total++;
            if (ack !== 3'b000) begin
                bad++; $display("FAIL basic_ack_width: actual=%b required=000", ack);
            end
        end
    endtask

    task automatic test_overflow();
        int lat; bit ok;
        do_req(1, 7'd127, lat, ok);
        total++;
        if (!ok || over[1] !== 1'b1 || {HEX3, HEX2} !== 16'hBFBF) begin
            bad++; $display("FAIL overflow_127: actual=over%b %h %h required=over1 bf bf", over[1], HEX3, HEX2);
        end
        tick();
        do_req(1, 7'd99, lat, ok);
        total++;
        if (!ok || over[1] !== 1'b0 || {HEX3, HEX2} !== 16'h9090) begin
            bad++; $display("FAIL overflow_99: actual=over%b %h %h required=over0 90 90", over[1], HEX3, HEX2);
        end
        do_req(1, 7'd100, lat, ok);
        total++;
        if (!ok || over[1] !== 1'b1 || {HEX3, HEX2} !== 16'hBFBF) begin
            bad++; $display("FAIL overflow_100: actual=over%b %h %h required=over1 bf bf", over[1], HEX3, HEX2);
        end
        do_req(1, 7'd0, lat, ok);
        total++;
        if (!ok || over[1] !== 1'b0 || HEX2 !== 8'hC0 || HEX3 !== exp_hex(3)) begin
            bad++; $display("FAIL overflow_0: actual=over%b %h %h required=over0 %h c0", over[1], HEX3, HEX2, exp_hex(3));
        end
    endtask

    task automatic test_leading_zero();
        int lat; bit ok;
        logic [7:0] tens_req;
`ifdef BLANK_LEADING_ZERO_EN
        tens_req = 8'hFF;
`else
        tens_req = 8'hC0;
`endif
        do_req(2, 7'd7, lat, ok);
        total++;
        if (!ok || HEX4 !== 8'hF8 || HEX5 !== tens_req) begin
            bad++; $display("FAIL leading_zero: actual=%h %h required=%h f8", HEX5, HEX4, tens_req);
        end
    endtask

    task automatic test_random();
        int lat; bit ok;
        int ch;
        logic [6:0] v;
        int unsigned bnd [6] = '{0, 9, 10, 99, 100, 127};
        for (int it = 0; it < 30; it++) begin
            ch = $urandom_range(2, 0);
            if ($urandom_range(3, 0) == 0) v = 7'(bnd[$urandom_range(5, 0)]);
            else v = 7'($urandom_range(127, 0));
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick();
            do_req(ch, v, lat, ok);
            total++;
            if (!ok || lat != 9) begin
                bad++; $display("FAIL random_latency: ch=%0d actual=%0d ok=%0d required=9", ch, lat, ok);
            end
            for (int k = 0; k < 6; k++) begin
                total++;
                if (hx[k] !== exp_hex(k)) begin
                    bad++; $display("FAIL random_hex%0d: val=%0d actual=%h required=%h", k, v, hx[k], exp_hex(k));
                end
            end
            total++;
            if (over !== exp_over()) begin
                bad++; $display("FAIL random_over: actual=%b required=%b", over, exp_over());
            end
        end
    endtask

    task automatic test_arbitration();
        int seen_ch [$];
        int seen_t  [$];
        int exp_t [3] = '{9, 18, 27};
        logic [6:0] vv [3];
        vv[0] = 7'd5; vv[1] = 7'd50; vv[2] = 7'd100;
        do_reset();
        val0 = vv[0]; val1 = vv[1]; val2 = vv[2];
        req = 3'b111;
        for (int n = 1; n <= 40 && seen_ch.size() < 3; n++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                if (ack[c]) begin
                    seen_ch.push_back(c); seen_t.push_back(n);
                    req[c] = 1'b0;
                    m_val[c] = vv[c]; m_valid[c] = 1;
                end
            end
        end
        req = 3'b000;
        total++;
        if (seen_ch.size() != 3) begin
            bad++; $display("FAIL arb_count: actual=%0d required=3", seen_ch.size());
        end
        for (int i = 0; i < seen_ch.size() && i < 3; i++) begin
            total++;
            if (seen_ch[i] != i || seen_t[i] != exp_t[i]) begin
                bad++; $display("FAIL arb_order%0d: actual=ch%0d@%0d required=ch%0d@%0d",
                                i, seen_ch[i], seen_t[i], i, exp_t[i]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (hx[k] !== exp_hex(k)) begin
                bad++; $display("FAIL arb_hex%0d: actual=%h required=%h", k, hx[k], exp_hex(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        int seen_ch [$];
        int last_t = 0;
        int exp_seq [4] = '{0, 1, 0, 1};
        do_reset();
        val0 = 7'($urandom_range(127, 0));
        val1 = 7'($urandom_range(127, 0));
        req = 3'b011;
        for (int n = 1; n <= 60 && seen_ch.size() < 4; n++) begin
            tick();
            for (int c = 0; c < 2; c++) begin
                if (ack[c]) begin
                    seen_ch.push_back(c);
                    total++;
                    if (n - last_t != 9) begin
                        bad++; $display("FAIL b2b_spacing: actual=%0d required=9", n - last_t);
                    end
                    last_t = n;
                    m_val[c] = (c == 0) ? int'(val0) : int'(val1); m_valid[c] = 1;
                end
            end
        end
        req = 3'b000;
        total++;
        if (seen_ch.size() != 4) begin
            bad++; $display("FAIL b2b_count: actual=%0d required=4", seen_ch.size());
        end
        for (int i = 0; i < seen_ch.size() && i < 4; i++) begin
            total++;
            if (seen_ch[i] != exp_seq[i]) begin
                bad++; $display("FAIL b2b_order%0d: actual=%0d required=%0d", i, seen_ch[i], exp_seq[i]);
            end
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (hx[k] !== exp_hex(k)) begin
                bad++; $display("FAIL b2b_hex%0d: actual=%h required=%h", k, hx[k], exp_hex(k));
            end
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int lat; bit ok;
        do_req(0, 7'd42, lat, ok);
        val1 = 7'($urandom_range(127, 0));
        req = 3'b010;
        tick();
        req = 3'b000;
        for (int n = 0; n < 4; n++) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL mid_busy_before: actual=%b required=1", busy);
        end
        do_reset();
        total++;
        if (busy !== 1'b0 || ack !== 3'b000 || over !== 3'b000) begin
            bad++; $display("FAIL mid_ctl: busy=%b ack=%b over=%b required=0", busy, ack, over);
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (hx[k] !== 8'hFF) begin
                bad++; $display("FAIL mid_hex%0d: actual=%h required=ff", k, hx[k]);
            end
        end
        for (int n = 0; n < 12; n++) begin
            tick();
            if (ack !== 3'b000) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++; $display("FAIL mid_no_ack: actual=%0d acks required=0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_leading_zero();
        test_random();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
